pacman_dir_ctrl: RTL and testbench
==================================

PACMAN_DIR_CTRL -- requirements
Module: pacman_dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles needed to accept a button level change (min 1).
REQ-002 Parameter MOVE_PERIOD, 24'd250000, cycles between successive move strobes while a direction is held (min 2).
REQ-003 i_clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_key_n  input  4  raw asynchronous push-buttons, active-low; bit3 left, bit2 right, bit1 up, bit0 down.
REQ-006 o_left, o_right, o_up, o_down  output  1 each  single-cycle move strobes for the position controller.
REQ-007 o_dir  output  3  current direction, dir_t encoding: IDLE=0, LEFT=1, RIGHT=2, UP=3, DOWN=4.

Function
REQ-008 Each i_key_n bit SHALL pass through a 2-flop synchronizer, then a debounce counter.
REQ-009 Debounced "pressed" SHALL toggle only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-010 Any cycle where the synchronized level equals the debounced level SHALL clear that button's counter; glitches shorter than DEBOUNCE_CYCLES produce no change.
REQ-011 Debounced level SHALL change exactly DEBOUNCE_CYCLES+2 cycles after a clean raw edge.
REQ-012 Arbitration SHALL be last-pressed-wins: a debounced press edge makes that button the current direction one cycle later.
REQ-013 Simultaneous press edges SHALL resolve by fixed priority LEFT > RIGHT > UP > DOWN.
REQ-014 Release of the current button SHALL select the highest-priority still-held button, else IDLE, one cycle after the debounced release.
REQ-015 Release of a non-current button SHALL not change o_dir or strobe timing.
REQ-016 A press edge of the already-current button is impossible; a press and a release in the same cycle SHALL apply the press rule.
REQ-017 A move counter SHALL count 0..MOVE_PERIOD-1 while o_dir != IDLE and SHALL be held at 0 while IDLE.
REQ-018 In the cycle o_dir takes a new non-IDLE value, the matching strobe SHALL assert and the counter SHALL load 1.
REQ-019 Further strobes SHALL assert when the counter wraps MOVE_PERIOD-1 -> 0, i.e. every MOVE_PERIOD cycles.
REQ-020 Strobes SHALL be registered, one-hot or all-zero, and SHALL match o_dir; no strobe while IDLE.
REQ-021 End-to-end: a clean raw press from IDLE SHALL give o_dir and the first strobe DEBOUNCE_CYCLES+3 cycles after the raw edge.

Reset
REQ-022 During reset: synchronizers read released (1), debounced levels released, debounce counters 0, move counter 0, o_dir=IDLE, all strobes 0.
REQ-023 Reset mid-operation SHALL abort immediately; after release a held button counts as a fresh press (REQ-021 timing).

Structure
REQ-024 Package pacman_pkg SHALL hold dir_t and the key bit-index constants KEY_LEFT=3, KEY_RIGHT=2, KEY_UP=1, KEY_DOWN=0.
REQ-025 Sub-module key_debounce SHALL hold the synchronizer and debounce counter for one button, with output pressed and one-cycle press/release pulses; it SHALL be instantiated 4 times.
REQ-026 Arbitration and the move counter SHALL live in pacman_dir_ctrl; expected size 150-250 lines total.

Verification (DEBOUNCE_CYCLES=4, MOVE_PERIOD=8)
REQ-027 Press LEFT at cycle 0 and hold -> o_dir=LEFT and o_left at cycle 7, then o_left at 15, 23, 31; no other strobes.
REQ-028 LEFT low-pulse of 3 cycles -> o_dir stays IDLE and no strobes; a 4+ cycle pulse -> accepted.
REQ-029 Hold UP, press RIGHT at cycle 40 -> o_dir=RIGHT with o_right at cycle 47, counter restarts; release RIGHT -> o_dir=UP with o_up 7 cycles after the release edge.
REQ-030 All four pressed in the same cycle -> o_dir=LEFT; release LEFT -> RIGHT; then release RIGHT -> UP.
REQ-031 Assert i_rst_n=0 mid-hold while DOWN is held -> outputs IDLE/0 at once; deassert with DOWN still held -> o_down 7 cycles later.
REQ-032 Throughout all scenarios, assert that at most one strobe is high per cycle and no strobe occurs while o_dir=IDLE.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man direction controller: direction encoding,
// button bit positions and the direction/button mapping helpers.
package pacman_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    localparam int KEY_LEFT  = 3;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 0;

    // One-hot button mask for a direction; IDLE maps to no button.
    function automatic logic [3:0] dir_mask(input dir_t d);
        logic [3:0] m;
        m = 4'b0000;
        case (d)
            DIR_LEFT:  m[KEY_LEFT]  = 1'b1;
            DIR_RIGHT: m[KEY_RIGHT] = 1'b1;
            DIR_UP:    m[KEY_UP]    = 1'b1;
            DIR_DOWN:  m[KEY_DOWN]  = 1'b1;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic dir_t pick_dir(input logic [3:0] keys);
        dir_t d;
        d = DIR_IDLE;
        if (keys[KEY_LEFT])       d = DIR_LEFT;
        else if (keys[KEY_RIGHT]) d = DIR_RIGHT;
        else if (keys[KEY_UP])    d = DIR_UP;
        else if (keys[KEY_DOWN])  d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer into a consecutive-cycle debounce
// counter, with registered pressed level and one-cycle press/release pulses.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    logic [1:0]  sync;
    logic [15:0] cnt;
    logic        level_now;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= 2'b11;
        else          sync <= {sync[0], key_n};
    end

    assign level_now = ~sync[1];

    // Counter runs only while the synchronized level disagrees with the
    // accepted level; any agreeing cycle restarts the qualification.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pressed       <= 1'b0;
            cnt           <= 16'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (level_now == pressed) begin
                cnt <= 16'd0;
            end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                cnt           <= 16'd0;
                pressed       <= level_now;
                press_pulse   <= level_now;
                release_pulse <= ~level_now;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pacman_dir_ctrl.sv
// Four debounced buttons arbitrated last-pressed-wins into a direction,
// plus a periodic move strobe for the currently selected direction.
module pacman_dir_ctrl
    import pacman_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] MOVE_PERIOD     = 24'd250000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key_n,
    output logic       o_left,
    output logic       o_right,
    output logic       o_up,
    output logic       o_down,
    output logic [2:0] o_dir
);

    logic [3:0]  held;
    logic [3:0]  press;
    logic [3:0]  rel;
    dir_t        dir;
    dir_t        next_dir;
    logic [23:0] move_cnt;
    logic [3:0]  strobe;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .key_n         (i_key_n[k]),
            .pressed       (held[k]),
            .press_pulse   (press[k]),
            .release_pulse (rel[k])
        );
    end

    // A press edge always wins over a simultaneous release; releasing a
    // button that is not the current direction is ignored.
    always_comb begin
        next_dir = dir;
        if (|press) begin
            next_dir = pick_dir(press);
        end else if (|(rel & dir_mask(dir))) begin
            next_dir = pick_dir(held);
        end
    end

    // move_cnt == 0 while moving marks the wrap, so the strobe lands the
    // cycle after it and repeats every MOVE_PERIOD cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir      <= DIR_IDLE;
            move_cnt <= 24'd0;
            strobe   <= 4'b0000;
        end else begin
            dir <= next_dir;
            if (next_dir == DIR_IDLE) begin
                move_cnt <= 24'd0;
                strobe   <= 4'b0000;
            end else if (next_dir != dir) begin
                move_cnt <= 24'd1;
                strobe   <= dir_mask(next_dir);
            end else begin
                move_cnt <= (move_cnt == MOVE_PERIOD - 24'd1) ? 24'd0 : move_cnt + 24'd1;
                strobe   <= (move_cnt == 24'd0) ? dir_mask(dir) : 4'b0000;
            end
        end
    end

    assign o_left  = strobe[KEY_LEFT];
    assign o_right = strobe[KEY_RIGHT];
    assign o_up    = strobe[KEY_UP];
    assign o_down  = strobe[KEY_DOWN];
    assign o_dir   = dir;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// Directed bench for pacman_dir_ctrl with DEBOUNCE_CYCLES=4, MOVE_PERIOD=8.
module tb_pacman_dir_ctrl;

    localparam logic [2:0] D_IDLE  = 3'd0;
    localparam logic [2:0] D_LEFT  = 3'd1;
    localparam logic [2:0] D_RIGHT = 3'd2;
    localparam logic [2:0] D_UP    = 3'd3;
    localparam logic [2:0] D_DOWN  = 3'd4;
    localparam int PERIOD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       left_s, right_s, up_s, down_s;
    logic [2:0] dir;

    int tests = 0;
    int fails = 0;

    pacman_dir_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .MOVE_PERIOD    (24'd8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_key_n (key_n),
        .o_left  (left_s),
        .o_right (right_s),
        .o_up    (up_s),
        .o_down  (down_s),
        .o_dir   (dir)
    );

    always #5 clk = ~clk;

    // Strobe pattern {left,right,up,down} expected for a direction.
    function automatic logic [3:0] exp_mask(input logic [2:0] d);
        case (d)
            D_LEFT:  return 4'b1000;
            D_RIGHT: return 4'b0100;
            D_UP:    return 4'b0010;
            D_DOWN:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [6:0] obs();
        return {dir, left_s, right_s, up_s, down_s};
    endfunction

    task automatic chk(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed dir/strobes=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks n cycles after inputs were driven at cycle 0. Before t0 the old
    // direction strobes whenever (i - ph_old) is a multiple of PERIOD; from t0
    // on the new direction holds with strobes at t0, t0+PERIOD, ...
    task automatic window(input string tag, input int n, input int t0,
                          input logic [2:0] d_old, input int ph_old, input logic [2:0] d_new);
        logic [2:0] ed;
        logic [3:0] es;
        int k;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i >= t0) begin
                ed = d_new;
                es = (((i - t0) % PERIOD) == 0) ? exp_mask(d_new) : 4'b0000;
            end else begin
                ed = d_old;
                k  = (((i - ph_old) % PERIOD) + PERIOD) % PERIOD;
                es = (k == 0) ? exp_mask(d_old) : 4'b0000;
            end
            chk($sformatf("%s@%0d", tag, i), obs(), {ed, es});
        end
    endtask

    // Every cycle: strobes are zero or exactly the current direction's strobe.
    always @(negedge clk) begin
        logic [3:0] s;
        s = {left_s, right_s, up_s, down_s};
        tests++;
        assert ((s == 4'b0000) || (s == exp_mask(dir) && dir != D_IDLE))
        else begin
            fails++;
            $error("FAIL strobe_invariant: dir=%0d strobes=%b required none or one-hot matching dir", dir, s);
        end
    end

    initial begin
        #2;
        chk("reset_state", obs(), 7'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_reset", obs(), 7'b0);

        // Press LEFT and hold: dir and strobe at 7, then 15, 23, 31.
        key_n = 4'b0111;
        window("left_hold", 33, 7, D_IDLE, 0, D_LEFT);
        key_n = 4'b1111;
        window("left_release", 10, 7, D_LEFT, -2, D_IDLE);

        // 3-cycle glitch rejected.
        key_n = 4'b0111;
        window("glitch3", 3, 99, D_IDLE, 0, D_IDLE);
        key_n = 4'b1111;
        window("glitch3_after", 12, 99, D_IDLE, 0, D_IDLE);

        // 4-cycle pulse accepted: press at 7, release debounced -> IDLE at 11.
        key_n = 4'b0111;
        window("pulse4_low", 4, 99, D_IDLE, 0, D_IDLE);
        key_n = 4'b1111;
        window("pulse4_press", 4, 3, D_IDLE, 0, D_LEFT);
        window("pulse4_release", 6, 3, D_LEFT, -1, D_IDLE);

        // Hold UP, then RIGHT overrides at 40; release RIGHT returns to UP.
        key_n = 4'b1101;
        window("up_press", 40, 7, D_IDLE, 0, D_UP);
        key_n = 4'b1001;
        window("right_over_up", 16, 7, D_UP, -1, D_RIGHT);
        key_n = 4'b1101;
        window("right_release", 16, 7, D_RIGHT, -1, D_UP);
        key_n = 4'b1111;
        window("up_release", 10, 7, D_UP, -1, D_IDLE);

        // All four at once: priority LEFT, then RIGHT, then UP on releases.
        key_n = 4'b0000;
        window("all_press", 10, 7, D_IDLE, 0, D_LEFT);
        key_n = 4'b1000;
        window("left_off", 10, 7, D_LEFT, -3, D_RIGHT);
        key_n = 4'b1100;
        window("right_off", 10, 7, D_RIGHT, -3, D_UP);
        key_n = 4'b1111;
        window("all_off", 10, 7, D_UP, -3, D_IDLE);

        // Reset mid-hold of DOWN, then restart as a fresh press.
        key_n = 4'b1110;
        window("down_press", 12, 7, D_IDLE, 0, D_DOWN);
        rst_n = 1'b0;
        #1;
        chk("reset_async", obs(), 7'b0);
        tick();
        chk("reset_held", obs(), 7'b0);
        tick();
        rst_n = 1'b1;
        window("down_after_reset", 16, 7, D_IDLE, 0, D_DOWN);
        key_n = 4'b1111;
        window("down_release", 10, 7, D_DOWN, -1, D_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
